// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch block
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEPTH_DEFAULT = 4;

    // Highest opcode the cpu understands; larger bytes are illegal when filtering
    localparam logic [7:0] OPCODE_MAX = 8'h07;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction byte FIFO with wrapping pointers and occupancy count
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head = mem[rd_ptr];

    // Storage write; callers never push while in reset, so no reset is needed here
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - byte fetch FIFO feeding a cpu with paced write strobes; INSTR_FILTER_EN enables opcode filtering
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [WIDTH-1:0]           IN_DATA,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic                       CPU_READY,
    output logic [WIDTH-1:0]           INSTRUCTION,
    output logic                       WRITE_EN,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       ILLEGAL
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] head;
    logic             accept;
    logic             drop;
    logic             push;
    logic             pop;

    // Input is blocked while reset is held even though the FIFO reads empty
    assign IN_READY = RESET && (COUNT != CW'(DEPTH));
    assign accept   = IN_VALID && IN_READY;
    assign push     = accept && !drop;
    assign pop      = (state == IDLE) && CPU_READY && (COUNT != '0);

`ifdef INSTR_FILTER_EN
    assign drop = (IN_DATA > WIDTH'(OPCODE_MAX));

    // Sticky flag: any dropped opcode is remembered until reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ILLEGAL <= 1'b0;
        end else if (accept && drop) begin
            ILLEGAL <= 1'b1;
        end
    end
`else
    assign drop    = 1'b0;
    assign ILLEGAL = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (CLK),
        .resetn    (RESET),
        .push      (push),
        .push_data (IN_DATA),
        .pop       (pop),
        .head      (head),
        .count     (COUNT)
    );

    // Issue sequencer: one strobe, then a bubble, so the cpu sees at most one byte per 3 cycles
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state       <= IDLE;
            INSTRUCTION <= '0;
            WRITE_EN    <= 1'b0;
        end else begin
            WRITE_EN <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        INSTRUCTION <= head;
                        WRITE_EN    <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE:   state <= GAP;
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with a queue-based reference model
module tb_instr_fetch;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

`ifdef INSTR_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RESET;
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic             CPU_READY;
    logic [WIDTH-1:0] INSTRUCTION;
    logic             WRITE_EN;
    logic [2:0]       COUNT;
    logic             ILLEGAL;

    instr_fetch #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN_DATA     (IN_DATA),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .CPU_READY   (CPU_READY),
        .INSTRUCTION (INSTRUCTION),
        .WRITE_EN    (WRITE_EN),
        .COUNT       (COUNT),
        .ILLEGAL     (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: a byte queue, a cooldown for the issue pacing, and the expected outputs
    logic [7:0] m_q[$];
    logic [7:0] m_instr;
    logic       m_we;
    logic       m_ill;
    int         m_cool;

    // Observed strobes (value and edge number)
    logic [7:0] got_v[$];
    int         got_t[$];

    task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic rst);
        bit acc;
        IN_VALID  = v;
        IN_DATA   = d;
        CPU_READY = rdy;
        RESET     = rst;
        acc = v && (m_q.size() < DEPTH);
        @(posedge CLK);
        cyc++;
        if (!rst) begin
            m_q.delete();
            m_cool  = 0;
            m_we    = 1'b0;
            m_instr = 8'h00;
            m_ill   = 1'b0;
        end else begin
            if (m_cool == 0 && m_q.size() > 0 && rdy) begin
                m_instr = m_q.pop_front();
                m_we    = 1'b1;
                m_cool  = 2;
            end else begin
                m_we = 1'b0;
                if (m_cool > 0) m_cool--;
            end
            if (acc) begin
                if (FILT && d > 8'h07) m_ill = 1'b1;
                else m_q.push_back(d);
            end
        end
        #1;
        if (WRITE_EN === 1'b1) begin
            got_v.push_back(INSTRUCTION);
            got_t.push_back(cyc);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        got_v.delete();
        got_t.delete();
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (COUNT !== 3'd0 || WRITE_EN !== 1'b0 || INSTRUCTION !== 8'h00 || ILLEGAL !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d we=%b instr=%h ill=%b required 0/0/00/0", COUNT, WRITE_EN, INSTRUCTION, ILLEGAL);
        end
        n_checks++;
        if (IN_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 0", IN_READY);
        end
        do_reset();
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b1);
        step(1'b1, 8'h03, 1'b0, 1'b1);
        n_checks++;
        if (COUNT !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_prefill: count=%0d required 3", COUNT);
        end
        step(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (WRITE_EN !== 1'b1 || INSTRUCTION !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_inflight_issue: we=%b instr=%h required 1/01", WRITE_EN, INSTRUCTION);
        end
        step(1'b1, 8'h05, 1'b1, 1'b0);
        n_checks++;
        if (COUNT !== 3'd0 || WRITE_EN !== 1'b0 || INSTRUCTION !== 8'h00 || IN_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop: count=%0d we=%b instr=%h rdy=%b required 0/0/00/0", COUNT, WRITE_EN, INSTRUCTION, IN_READY);
        end
        got_v.delete();
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (got_v.size() != 0 || COUNT !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_discard: strobes=%0d count=%0d required 0/0", got_v.size(), COUNT);
        end
    endtask

    task automatic test_ordering();
        int t0;
        logic [7:0] exp_v[3];
        exp_v[0] = 8'h01; exp_v[1] = 8'h02; exp_v[2] = 8'h04;
        do_reset();
        step(1'b1, 8'h01, 1'b1, 1'b1);
        t0 = cyc;
        n_checks++;
        if (COUNT !== 3'd1 || WRITE_EN !== 1'b0) begin
            n_fail++;
            $display("FAIL order_first_accept: count=%0d we=%b required 1/0", COUNT, WRITE_EN);
        end
        step(1'b1, 8'h02, 1'b1, 1'b1);
        step(1'b1, 8'h04, 1'b1, 1'b1);
        drain(12);
        n_checks++;
        if (got_v.size() != 3) begin
            n_fail++;
            $display("FAIL order_count: strobes=%0d required 3", got_v.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < got_v.size()) begin
                n_checks++;
                if (got_v[i] !== exp_v[i] || got_t[i] != t0 + 1 + 3 * i) begin
                    n_fail++;
                    $display("FAIL order_pulse%0d: value=%h edge=%0d required %h at edge %0d", i, got_v[i], got_t[i], exp_v[i], t0 + 1 + 3 * i);
                end
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        n_checks++;
        if (COUNT !== 3'd4 || IN_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: count=%0d in_ready=%b required 4/0", COUNT, IN_READY);
        end
        drain(16);
        n_checks++;
        if (got_v.size() != 4) begin
            n_fail++;
            $display("FAIL full_drain_count: strobes=%0d required 4", got_v.size());
        end
        for (int i = 0; i < got_v.size(); i++) begin
            n_checks++;
            if (got_v[i] !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL full_drain%0d: value=%h required %h", i, got_v[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b1);
        step(1'b1, 8'h03, 1'b1, 1'b1);
        n_checks++;
        if (COUNT !== 3'd2 || WRITE_EN !== 1'b1 || INSTRUCTION !== 8'h01) begin
            n_fail++;
            $display("FAIL simul_edge: count=%0d we=%b instr=%h required 2/1/01", COUNT, WRITE_EN, INSTRUCTION);
        end
        drain(10);
        n_checks++;
        if (got_v.size() != 3 || got_v[got_v.size() - 1] !== 8'h03) begin
            n_fail++;
            $display("FAIL simul_order: strobes=%0d last=%h required 3/03", got_v.size(), got_v.size() > 0 ? got_v[got_v.size() - 1] : 8'hxx);
        end
    endtask

    task automatic test_filter();
        logic [7:0] exp_q[$];
        do_reset();
        step(1'b1, 8'h05, 1'b0, 1'b1);
        step(1'b1, 8'hA0, 1'b0, 1'b1);
        n_checks++;
        if (ILLEGAL !== FILT || COUNT !== (FILT ? 3'd1 : 3'd2) || IN_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL filter_after_a0: ill=%b count=%0d rdy=%b required %b/%0d/1", ILLEGAL, COUNT, IN_READY, FILT, FILT ? 1 : 2);
        end
        step(1'b1, 8'h06, 1'b0, 1'b1);
        drain(12);
        if (FILT) exp_q = '{8'h05, 8'h06};
        else exp_q = '{8'h05, 8'hA0, 8'h06};
        n_checks++;
        if (got_v != exp_q || ILLEGAL !== FILT) begin
            n_fail++;
            $display("FAIL filter_issue: strobes=%p ill=%b required %p/%b", got_v, ILLEGAL, exp_q, FILT);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (ILLEGAL !== 1'b0) begin
            n_fail++;
            $display("FAIL filter_clear: ill=%b required 0", ILLEGAL);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(1'b1, 8'h07, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            n_checks++;
            if (WRITE_EN !== 1'b0 || COUNT !== 3'd1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: we=%b count=%0d required 0/1", i, WRITE_EN, COUNT);
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (WRITE_EN !== 1'b1 || INSTRUCTION !== 8'h07 || COUNT !== 3'd0) begin
            n_fail++;
            $display("FAIL stall_release: we=%b instr=%h count=%0d required 1/07/0", WRITE_EN, INSTRUCTION, COUNT);
        end
    endtask

    task automatic test_random();
        logic prev_we;
        do_reset();
        prev_we = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 49) != 0));
            n_checks++;
            if (WRITE_EN !== m_we || INSTRUCTION !== m_instr || COUNT !== 3'(m_q.size())
                || ILLEGAL !== m_ill || IN_READY !== (RESET && m_q.size() != DEPTH)) begin
                n_fail++;
                $display("FAIL random_cycle%0d: we=%b instr=%h count=%0d ill=%b rdy=%b required %b/%h/%0d/%b/%b",
                         i, WRITE_EN, INSTRUCTION, COUNT, ILLEGAL, IN_READY,
                         m_we, m_instr, m_q.size(), m_ill, RESET && m_q.size() != DEPTH);
            end
            n_checks++;
            if (prev_we === 1'b1 && WRITE_EN === 1'b1) begin
                n_fail++;
                $display("FAIL random_back_to_back%0d: we high on two consecutive cycles, required single-cycle", i);
            end
            prev_we = WRITE_EN;
        end
    endtask

    initial begin
        RESET     = 1'b0;
        IN_VALID  = 1'b0;
        IN_DATA   = 8'h00;
        CPU_READY = 1'b0;
        m_instr   = 8'h00;
        m_we      = 1'b0;
        m_ill     = 1'b0;
        m_cool    = 0;
        #1;
        test_reset();
        test_ordering();
        test_full();
        test_simultaneous();
        test_filter();
        test_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
